// File: rtl/mips_pkg.sv
// Shared register-file types used by the decode-stage write arbiter.
package mips_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // One candidate write to the register file port.
    typedef struct packed {
        logic            valid;
        reg_idx_t        addr;
        logic [XLEN-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester, hazard-check and register-file port signals of the write arbiter.
interface regfile_wr_arbiter_if
    import mips_pkg::*;
#(
    parameter int DW = XLEN
);
    logic          wb_we;
    reg_idx_t      wb_addr;
    logic [DW-1:0] wb_data;
    logic          md_valid;
    reg_idx_t      md_addr;
    logic [DW-1:0] md_data;
    logic          md_ready;
    logic          dbg_req;
    reg_idx_t      dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          dbg_ack;
    reg_idx_t      chk_rs;
    reg_idx_t      chk_rt;
    reg_idx_t      chk_rd;
    logic          pend_hazard;
    logic          stall_req;
    logic          reg_write;
    reg_idx_t      write_register;
    logic [DW-1:0] write_data_reg;

    // Requesters and decode logic side.
    modport master (
        output wb_we, wb_addr, wb_data,
        output md_valid, md_addr, md_data,
        output dbg_req, dbg_addr, dbg_data,
        output chk_rs, chk_rt, chk_rd,
        input  md_ready, dbg_ack, pend_hazard, stall_req,
        input  reg_write, write_register, write_data_reg
    );

    // Arbiter side.
    modport slave (
        input  wb_we, wb_addr, wb_data,
        input  md_valid, md_addr, md_data,
        input  dbg_req, dbg_addr, dbg_data,
        input  chk_rs, chk_rt, chk_rd,
        output md_ready, dbg_ack, pend_hazard, stall_req,
        output reg_write, write_register, write_data_reg
    );
endinterface

// File: rtl/wr_result_fifo.sv
// Mul/div result buffer: per-entry valid bits so a newer writeback can cancel
// a stale result in place, plus a combinational destination lookup.
module wr_result_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = XLEN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq,
    input  reg_idx_t      enq_addr,
    input  logic [DW-1:0] enq_data,
    input  logic          pop,
    input  logic          cancel_en,
    input  reg_idx_t      cancel_addr,
    input  reg_idx_t      chk_rs,
    input  reg_idx_t      chk_rt,
    input  reg_idx_t      chk_rd,
    output logic          full,
    output logic          empty,
    output logic          head_valid,
    output reg_idx_t      head_addr,
    output logic [DW-1:0] head_data,
    output logic          pend_hit
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH) + 1;

    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [CNTW-1:0]  count_reg;
    logic [DEPTH-1:0] vld_reg;
    logic [DEPTH-1:0] vld_next;
    logic [DEPTH-1:0] hit_vec;
    reg_idx_t         addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];

    // Cancelled entries keep their slot; they count towards occupancy until popped.
    assign full       = (count_reg == CNTW'(DEPTH));
    assign empty      = (count_reg == '0);
    assign head_valid = vld_reg[rd_ptr_reg];
    assign head_addr  = addr_mem[rd_ptr_reg];
    assign head_data  = data_mem[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign hit_vec[gi] = vld_reg[gi] &&
                ((chk_rs != REG_ZERO && addr_mem[gi] == chk_rs) ||
                 (chk_rt != REG_ZERO && addr_mem[gi] == chk_rt) ||
                 (chk_rd != REG_ZERO && addr_mem[gi] == chk_rd));
        end
    endgenerate

    assign pend_hit = |hit_vec;

    // Valid bits: cancel on address match, clear on pop, a new push wins.
    always_comb begin
        vld_next = vld_reg;
        for (int i = 0; i < DEPTH; i++) begin
            if (cancel_en && addr_mem[i] == cancel_addr) begin
                vld_next[i] = 1'b0;
            end
        end
        if (pop) begin
            vld_next[rd_ptr_reg] = 1'b0;
        end
        if (enq) begin
            vld_next[wr_ptr_reg] = 1'b1;
        end
    end

    // Pointers, occupancy and valid bits; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            vld_reg    <= '0;
        end else begin
            vld_reg   <= vld_next;
            count_reg <= count_reg + CNTW'(enq) - CNTW'(pop);
            if (enq) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end
    end

    // Entry payload storage; contents are meaningless while the valid bit is 0.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr_reg] <= enq_addr;
            data_mem[wr_ptr_reg] <= enq_data;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between pipeline writeback, buffered
// mul/div results and the debug loader, in that fixed priority.
module regfile_wr_arbiter
    import mips_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int DW           = XLEN
) (
    input logic                clk,
    input logic                rst,
    regfile_wr_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic          wb_hit;
    logic          md_push;
    logic          md_enq;
    logic          dbg_slot;
    logic          fifo_full;
    logic          fifo_empty;
    logic          head_valid;
    logic          head_live;
    logic          head_grant;
    logic          fifo_pop;
    logic          pend_hit;
    reg_idx_t      head_addr;
    logic [DW-1:0] head_data;
    wr_req_t       port_wr;
    logic [CW-1:0] starve_cnt_reg;
    logic [CW-1:0] starve_cnt_next;
    logic          stall_req_reg;
    logic          stall_req_next;

    // Nothing is granted while reset is held, so a pending debug request is
    // arbitrated again once reset releases.
    assign wb_hit     = !rst && bus.wb_we && (bus.wb_addr != REG_ZERO);
    assign md_push    = !rst && bus.md_valid && !fifo_full;
    assign md_enq     = md_push && (bus.md_addr != REG_ZERO);
    assign head_live  = !fifo_empty && head_valid;
    assign head_grant = head_live && !wb_hit;
    // A cancelled head is dropped without using the port.
    assign fifo_pop   = head_grant || (!fifo_empty && !head_valid);
    assign dbg_slot   = !rst && bus.dbg_req && !wb_hit && !head_live;

    wr_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .enq         (md_enq),
        .enq_addr    (bus.md_addr),
        .enq_data    (bus.md_data),
        .pop         (fifo_pop),
        .cancel_en   (wb_hit),
        .cancel_addr (bus.wb_addr),
        .chk_rs      (bus.chk_rs),
        .chk_rt      (bus.chk_rt),
        .chk_rd      (bus.chk_rd),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head_valid  (head_valid),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .pend_hit    (pend_hit)
    );

    // Port mux: writeback, then live FIFO head, then a nonzero debug write.
    always_comb begin
        port_wr = '0;
        if (wb_hit) begin
            port_wr = '{valid: 1'b1, addr: bus.wb_addr, data: XLEN'(bus.wb_data)};
        end else if (head_live) begin
            port_wr = '{valid: 1'b1, addr: head_addr, data: XLEN'(head_data)};
        end else if (dbg_slot && bus.dbg_addr != REG_ZERO) begin
            port_wr = '{valid: 1'b1, addr: bus.dbg_addr, data: XLEN'(bus.dbg_data)};
        end
    end

    assign bus.reg_write      = port_wr.valid;
    assign bus.write_register = port_wr.addr;
    assign bus.write_data_reg = DW'(port_wr.data);
    assign bus.md_ready       = !fifo_full;
    assign bus.dbg_ack        = dbg_slot;
    assign bus.pend_hazard    = pend_hit;
    assign bus.stall_req      = stall_req_reg;

    // Starvation tracking: count lost head grants, hold stall until the FIFO drains.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        stall_req_next  = stall_req_reg;
        if (fifo_empty) begin
            starve_cnt_next = '0;
            stall_req_next  = 1'b0;
        end else if (head_grant) begin
            starve_cnt_next = '0;
        end else if (head_live) begin
            if (starve_cnt_reg < CW'(STARVE_LIMIT)) begin
                starve_cnt_next = starve_cnt_reg + CW'(1);
            end
            if (starve_cnt_reg >= CW'(STARVE_LIMIT - 1)) begin
                stall_req_next = 1'b1;
            end
        end
    end

    // Starvation state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg <= '0;
            stall_req_reg  <= 1'b0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            stall_req_reg  <= stall_req_next;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: combinational vector table, directed
// multi-cycle sequences and random traffic against a queue-based model.
module tb_regfile_wr_arbiter;
    import mips_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.DW(32)) bus ();

    regfile_wr_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT),
        .DW           (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: queue of buffered results in arrival order, cancelled ones kept as invalid.
    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;
    ent_t q[$];
    int   m_cnt;
    bit   m_stall;

    typedef struct {
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        dbg_req;
        logic [4:0]  dbg_addr;
        logic [31:0] dbg_data;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_ack;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.wb_we = 0;  bus.wb_addr = 0;  bus.wb_data = 0;
        bus.md_valid = 0; bus.md_addr = 0; bus.md_data = 0;
        bus.dbg_req = 0; bus.dbg_addr = 0; bus.dbg_data = 0;
        bus.chk_rs = 0; bus.chk_rt = 0; bus.chk_rd = 0;
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt   = 0;
        m_stall = 0;
    endtask

    // One clock cycle: predict and compare outputs, clock, advance the model.
    task automatic cycle();
        logic        wbh, live, pop, e_we, e_ack, e_pend, e_rdy;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        int          sz;
        wbh  = bus.wb_we && (bus.wb_addr != 0);
        live = (q.size() > 0) && q[0].v;
        e_we = 0; e_a = 0; e_d = 0;
        if (wbh) begin
            e_we = 1; e_a = bus.wb_addr; e_d = bus.wb_data;
        end else if (live) begin
            e_we = 1; e_a = q[0].a; e_d = q[0].d;
        end else if (bus.dbg_req && bus.dbg_addr != 0) begin
            e_we = 1; e_a = bus.dbg_addr; e_d = bus.dbg_data;
        end
        e_ack  = bus.dbg_req && !wbh && !live;
        e_rdy  = (q.size() < DEPTH);
        e_pend = 0;
        foreach (q[i]) begin
            if (q[i].v && ((bus.chk_rs != 0 && q[i].a == bus.chk_rs) ||
                           (bus.chk_rt != 0 && q[i].a == bus.chk_rt) ||
                           (bus.chk_rd != 0 && q[i].a == bus.chk_rd)))
                e_pend = 1;
        end
        #2;
        check("reg_write", bus.reg_write, e_we);
        check("write_register", bus.write_register, e_a);
        check("write_data_reg", bus.write_data_reg, e_d);
        check("dbg_ack", bus.dbg_ack, e_ack);
        check("md_ready", bus.md_ready, e_rdy);
        check("pend_hazard", bus.pend_hazard, e_pend);
        check("stall_req", bus.stall_req, m_stall);
        @(posedge clk);
        sz  = q.size();
        pop = (live && !wbh) || (sz > 0 && !q[0].v);
        if (sz == 0) begin
            m_cnt = 0; m_stall = 0;
        end else if (live && !wbh) begin
            m_cnt = 0;
        end else if (live) begin
            m_cnt++;
            if (m_cnt >= LIMIT) begin
                m_cnt = LIMIT; m_stall = 1;
            end
        end
        if (wbh) begin
            foreach (q[i]) if (q[i].a == bus.wb_addr) q[i].v = 0;
        end
        if (pop) void'(q.pop_front());
        if (bus.md_valid && e_rdy && bus.md_addr != 0)
            q.push_back('{v: 1'b1, a: bus.md_addr, d: bus.md_data});
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1, 5'd5, 32'h1234, 0, 5'd0,  32'h0,  1, 5'd5,  32'h1234, 0};
        vecs[1] = '{1, 5'd0, 32'hDEAD, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,    0};
        vecs[2] = '{0, 5'd0, 32'h0,    1, 5'd12, 32'h55, 1, 5'd12, 32'h55,   1};
        vecs[3] = '{0, 5'd0, 32'h0,    1, 5'd0,  32'h66, 0, 5'd0,  32'h0,    1};
        vecs[4] = '{1, 5'd5, 32'h1234, 1, 5'd12, 32'h55, 1, 5'd5,  32'h1234, 0};
        vecs[5] = '{1, 5'd0, 32'hBEEF, 1, 5'd12, 32'h55, 1, 5'd12, 32'h55,   1};

        // Reset state.
        rst = 1;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst reg_write", bus.reg_write, 0);
        check("rst md_ready", bus.md_ready, 1);
        check("rst stall_req", bus.stall_req, 0);
        check("rst write_register", bus.write_register, 0);
        check("rst write_data_reg", bus.write_data_reg, 0);
        check("rst pend_hazard", bus.pend_hazard, 0);
        rst = 0;

        // Combinational priority with the FIFO empty.
        for (int i = 0; i < 6; i++) begin
            bus.wb_we = vecs[i].wb_we; bus.wb_addr = vecs[i].wb_addr; bus.wb_data = vecs[i].wb_data;
            bus.dbg_req = vecs[i].dbg_req; bus.dbg_addr = vecs[i].dbg_addr; bus.dbg_data = vecs[i].dbg_data;
            #2;
            check($sformatf("vec%0d reg_write", i), bus.reg_write, vecs[i].e_we);
            check($sformatf("vec%0d write_register", i), bus.write_register, vecs[i].e_addr);
            check($sformatf("vec%0d write_data_reg", i), bus.write_data_reg, vecs[i].e_data);
            check($sformatf("vec%0d dbg_ack", i), bus.dbg_ack, vecs[i].e_ack);
            @(posedge clk);
            #1;
        end
        set_idle();

        // Single mul/div result, one-cycle latency, hazard flag lifetime.
        bus.md_valid = 1; bus.md_addr = 8; bus.md_data = 32'hCAFE;
        #1 check("A md_ready", bus.md_ready, 1);
        check("A no bypass", bus.reg_write, 0);
        cycle();
        bus.md_valid = 0; bus.chk_rs = 8;
        #1 check("A pend before", bus.pend_hazard, 1);
        check("A r8 addr", bus.write_register, 8);
        check("A r8 data", bus.write_data_reg, 32'hCAFE);
        cycle();
        #1 check("A pend after", bus.pend_hazard, 0);
        cycle();
        set_idle();

        // Fill, starve for four cycles, drain, stall release.
        bus.md_valid = 1; bus.md_addr = 9; bus.md_data = 32'h99;
        cycle();
        bus.md_addr = 10; bus.md_data = 32'h1010;
        bus.wb_we = 1; bus.wb_addr = 3; bus.wb_data = 32'h33;
        cycle();
        bus.md_valid = 0;
        #1 check("B md_ready full", bus.md_ready, 0);
        cycle();
        cycle();
        #1 check("B no stall at 3", bus.stall_req, 0);
        cycle();
        bus.wb_we = 0;
        #1 check("B stall after 4", bus.stall_req, 1);
        check("B drain r9", bus.write_register, 9);
        cycle();
        #1 check("B drain r10", bus.write_register, 10);
        cycle();
        #1 check("B stall held", bus.stall_req, 1);
        check("B md_ready empty", bus.md_ready, 1);
        cycle();
        #1 check("B stall cleared", bus.stall_req, 0);
        cycle();

        // WAW cancel.
        bus.md_valid = 1; bus.md_addr = 7; bus.md_data = 32'hAA;
        cycle();
        bus.md_valid = 0; bus.wb_we = 1; bus.wb_addr = 7; bus.wb_data = 32'hBB;
        #1 check("C wb data", bus.write_data_reg, 32'hBB);
        cycle();
        bus.wb_we = 0;
        #1 check("C no stale", bus.reg_write, 0);
        cycle();
        #1 check("C still none", bus.reg_write, 0);
        cycle();

        // Debug behind a buffered result, then a debug request to r0.
        bus.md_valid = 1; bus.md_addr = 4; bus.md_data = 32'h44;
        cycle();
        bus.md_valid = 0;
        bus.dbg_req = 1; bus.dbg_addr = 12; bus.dbg_data = 32'h55;
        #1 check("D r4 first", bus.write_register, 4);
        check("D no ack yet", bus.dbg_ack, 0);
        cycle();
        #1 check("D ack", bus.dbg_ack, 1);
        check("D r12 data", bus.write_data_reg, 32'h55);
        cycle();
        bus.dbg_addr = 0;
        #1 check("D r0 ack", bus.dbg_ack, 1);
        check("D r0 no write", bus.reg_write, 0);
        cycle();
        set_idle();

        // Reset with two buffered results and a debug request pending.
        bus.md_valid = 1; bus.md_addr = 20; bus.md_data = 32'h2020;
        cycle();
        bus.md_addr = 21; bus.md_data = 32'h2121;
        bus.wb_we = 1; bus.wb_addr = 3; bus.wb_data = 32'h33;
        cycle();
        bus.md_valid = 0;
        bus.dbg_req = 1; bus.dbg_addr = 13; bus.dbg_data = 32'h77;
        bus.chk_rs = 20;
        #1 check("E full", bus.md_ready, 0);
        rst = 1;
        #1;
        check("E rst md_ready", bus.md_ready, 1);
        check("E rst reg_write", bus.reg_write, 0);
        check("E rst dbg_ack", bus.dbg_ack, 0);
        check("E rst pend", bus.pend_hazard, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        bus.wb_we = 0;
        #1 check("E dbg after rst", bus.write_register, 13);
        cycle();
        set_idle();
        cycle();
        cycle();

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            bus.wb_we    = ($urandom_range(0, 9) < 4);
            bus.wb_addr  = 5'($urandom_range(0, 7));
            bus.wb_data  = $urandom;
            bus.md_valid = ($urandom_range(0, 1) == 1);
            bus.md_addr  = 5'($urandom_range(0, 7));
            bus.md_data  = $urandom;
            bus.dbg_req  = ($urandom_range(0, 4) == 0);
            bus.dbg_addr = 5'($urandom_range(0, 15));
            bus.dbg_data = $urandom;
            bus.chk_rs   = 5'($urandom_range(0, 7));
            bus.chk_rt   = 5'($urandom_range(0, 7));
            bus.chk_rd   = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Owns the single write port of the decode-stage register file (reg_write / write_register / write_data_reg) and shares it between three requesters.
- Requesters: the pipeline writeback, a multi-cycle mul/div result source, and a debug/boot loader.
- Buffers mul/div results in a small FIFO and flags pending destinations to the decode hazard logic.
- Raises a front-end stall request when buffered results starve.

Parameters:
- FIFO_DEPTH, 2, mul/div result buffer entries; power of two, at least 2
- STARVE_LIMIT, 4, consecutive cycles a valid FIFO head may lose arbitration before stall_req asserts
- DW, 32, data width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- wb_we  in  1  pipeline writeback write enable
- wb_addr  in  5  pipeline writeback destination
- wb_data  in  DW  pipeline writeback data
- md_valid  in  1  mul/div result valid
- md_addr  in  5  mul/div destination
- md_data  in  DW  mul/div result
- md_ready  out  1  FIFO can accept
- dbg_req  in  1  debug write request, level, held until ack
- dbg_addr  in  5  debug destination
- dbg_data  in  DW  debug data
- dbg_ack  out  1  one-cycle pulse in the cycle the debug write is driven
- chk_rs, chk_rt, chk_rd  in  5 each  decode operand and destination indices to check
- pend_hazard  out  1  some valid FIFO entry targets a nonzero chk_rs, chk_rt or chk_rd
- stall_req  out  1  front-end hold request, registered
- reg_write  out  1  regfile write enable
- write_register  out  5  regfile write address
- write_data_reg  out  DW  regfile write data

Behaviour:
- Reset: FIFO empty with all valid bits 0, starvation counter 0, stall_req 0. All other outputs follow from that state: md_ready=1, reg_write=0, dbg_ack=0, pend_hazard=0, write_register=0, write_data_reg=0.
- Port outputs are combinational from the current inputs and the FIFO head, so pipeline writeback adds zero latency.
- Fixed priority, at most one write per cycle:
  - 1. Pipeline writeback: wb_we=1 and wb_addr≠0. It always wins and has no backpressure.
  - 2. Valid FIFO head: popped on grant.
  - 3. dbg_req with dbg_addr≠0. Granted only when 1 and 2 are both idle; dbg_ack=1 in that cycle.
- Writes to address 0 never drive reg_write:
  - wb_we to r0 is ignored.
  - A debug request to r0 is acked without a write.
  - An md beat to r0 is accepted (handshake completes) but not enqueued.
- md_ready = !full. It does not depend on md_valid, and there is no push when full even if the FIFO pops that cycle. Push happens when md_valid && md_ready.
- No bypass: the earliest port write of a pushed result is the next cycle, so latency is 1.
- WAW cancel: when pipeline writeback writes nonzero address X, every stored FIFO entry with addr X is invalidated (valid bit cleared). A beat pushed in the same cycle is enqueued normally.
- Invalid head: popped in one cycle without using the port, so a debug write may be granted that cycle. It does not count as starvation.
- Starvation counter:
  - Increments each cycle a valid head is not granted.
  - Clears on head grant or when the FIFO is empty.
  - stall_req sets when the counter reaches STARVE_LIMIT.
  - stall_req clears in the cycle after the FIFO becomes empty (count saturates).
- Debug has no starvation guarantee; debug is used only with the pipeline halted.
- FIFO pointers wrap modulo FIFO_DEPTH. An occupancy counter distinguishes full from empty.
- Asserting rst mid-operation discards all FIFO contents. A debug request pending across reset is re-arbitrated after reset.

Decomposition:
- Shared package `mips_pkg`:
  - typedef `reg_idx_t` (logic [4:0])
  - constant `REG_ZERO`
  - typedef `wr_req_t` struct {valid, addr, data}
- One sub-module, `wr_result_fifo`: the DEPTH-entry FIFO with per-entry valid bits, address-match cancel, and a combinational address lookup for pend_hazard.

Test Plan:
- Reset with no traffic: reg_write=0, md_ready=1, stall_req=0. Then wb_we=1, wb_addr=5, wb_data=0x1234 → same cycle reg_write=1, write_register=5, write_data_reg=0x1234.
- md_valid for one cycle, md_addr=8, md_data=0xCAFE, with wb idle → next cycle writes r8=0xCAFE. With chk_rs=8 in the push+1 cycle, pend_hazard=1 before the write and 0 after the pop.
- Push r9 then r10, FIFO_DEPTH=2 → md_ready=0. Continuous wb_we to r3 for 4 cycles → stall_req=1 on the 4th miss. After wb idles, r9 and r10 drain in 2 cycles; stall_req=0 the cycle after empty.
- Push r7=0xAA, then next cycle wb writes r7=0xBB → entry cancelled, and the port never writes 0xAA to r7.
- dbg_req r12=0x55 while the FIFO holds r4 → r4 written first, dbg_ack pulses one cycle later with r12=0x55. dbg_addr=0 → ack with reg_write=0.
- Assert rst while the FIFO holds 2 entries → FIFO empties immediately, md_ready=1, and no stale write after release.
